// File: rtl/mips_shift_pkg.sv
// Shared encodings for the iterative shift unit: shift opcodes and FSM states.
// Latency: none (constants only).
// Backpressure: none (constants only).
package mips_shift_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// One partial shift of up to STEP bits (SLL/SRL/SRA/ROTR) on a WIDTH-bit word.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module shift_step
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AMT_W = 3
) (
    input  logic [WIDTH-1:0] src_dat,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic             fill_bit,
    output logic [WIDTH-1:0] res_dat
);

    // Select one of STEP+1 constant-distance shifts; each candidate is just wiring,
    // so the cost is a (STEP+1)-way mux rather than a full barrel shifter.
    always_comb begin
        res_dat = src_dat;
        for (int i = 1; i <= STEP; i++) begin
            if (int'(amt) == i) begin
                case (op)
                    OP_SLL:  res_dat = src_dat << i;
                    OP_SRL:  res_dat = src_dat >> i;
                    OP_SRA:  res_dat = (src_dat >> i) |
                                       ({WIDTH{fill_bit}} & ~({WIDTH{1'b1}} >> i));
                    default: res_dat = (src_dat >> i) | (src_dat << (WIDTH - i));
                endcase
            end
        end
    end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROTR shifter, moving up to STEP bits per cycle, start/done handshake.
// Latency: done pulses 1+max(1,ceil(shamt/STEP)) edges counting the edge that samples start.
// Backpressure: busy is high outside IDLE; start is ignored (not queued) while busy.
module iterative_shift_unit
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         out_data
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int AMT_W = $clog2(STEP + 1);

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic             sign_q;
    logic [SHW-1:0]   remaining;
    logic [WIDTH-1:0] work_dat;
    logic [WIDTH-1:0] step_dat;
    logic [AMT_W-1:0] step_amt;
    logic             last_step;

    // Per-cycle distance: a full STEP, or whatever is left on the final cycle.
    always_comb begin
        last_step = (int'(remaining) <= STEP);
        step_amt  = AMT_W'(remaining);
        if (!last_step) begin
            step_amt = AMT_W'(STEP);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_shift_step (
        .src_dat  (work_dat),
        .op       (op_q),
        .amt      (step_amt),
        .fill_bit (sign_q),
        .res_dat  (step_dat)
    );

    // Control FSM plus work/result registers; operands are captured only on accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_SLL;
            sign_q    <= 1'b0;
            remaining <= '0;
            work_dat  <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        work_dat  <= in_data;
                        op_q      <= op;
                        sign_q    <= in_data[WIDTH-1];
                        remaining <= shamt;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work_dat <= step_dat;
                    if (last_step) begin
                        remaining <= '0;
                        out_data  <= step_dat;
                        state     <= ST_DONE;
                    end else begin
                        remaining <= SHW'(int'(remaining) - STEP);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench: three instances (STEP=1, 4, 32) driven from scenario tasks.
// Latency: measured in edges from the edge that samples start to done observed.
// Backpressure: start pulses during busy are checked to be ignored.
module tb_iterative_shift_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [2:0]       start_v;
    logic [2:0][1:0]  op_v;
    logic [2:0][31:0] in_v;
    logic [2:0][4:0]  shamt_v;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;
    logic [2:0][31:0] out_v;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        iterative_shift_unit #(
            .WIDTH (32),
            .STEP  (g == 0 ? 1 : (g == 1 ? 4 : 32))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start_v[g]),
            .op       (op_v[g]),
            .in_data  (in_v[g]),
            .shamt    (shamt_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .out_data (out_v[g])
        );
    end

    typedef struct {
        logic [31:0] dat;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic int step_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 4 : 32);
    endfunction

    function automatic int exp_lat(input int sh, input int step);
        int k;
        k = (sh + step - 1) / step;
        if (k < 1) k = 1;
        return 1 + k;
    endfunction

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x, input int sh);
        logic [63:0] dbl;
        case (op)
            2'b00:   return x << sh;
            2'b01:   return x >> sh;
            2'b10:   return 32'($signed(x) >>> sh);
            default: begin
                dbl = {x, x} >> sh;
                return dbl[31:0];
            end
        endcase
    endfunction

    // Issue one request, wait (bounded) for done, then compare against the scoreboard.
    task automatic issue_and_check(input int idx, input logic [1:0] op, input logic [31:0] data,
                                   input int sh, input logic [31:0] exp_dat, input string name);
        exp_t e;
        int   cycles;
        bit   got;
        exp_q.push_back('{exp_dat, exp_lat(sh, step_of(idx))});
        @(negedge clk);
        op_v[idx]    = op;
        in_v[idx]    = data;
        shamt_v[idx] = 5'(sh);
        start_v[idx] = 1'b1;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 80) begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == 1) begin
                start_v[idx] = 1'b0;
                in_v[idx]    = $urandom;
                op_v[idx]    = 2'($urandom);
                shamt_v[idx] = 5'($urandom);
            end
            if (done_v[idx] === 1'b1) got = 1'b1;
        end
        e = exp_q.pop_front();
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s timeout: no done within %0d edges (step %0d)", name, cycles, step_of(idx));
        end else begin
            if (out_v[idx] !== e.dat) begin
                tests_failed++;
                $display("FAIL %s data: got %h expected %h (step %0d)", name, out_v[idx], e.dat, step_of(idx));
            end
            tests_run++;
            if (cycles != e.lat) begin
                tests_failed++;
                $display("FAIL %s latency: got %0d expected %0d (step %0d)", name, cycles, e.lat, step_of(idx));
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (done_v[idx] !== 1'b0 || busy_v[idx] !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s after_done: done=%b busy=%b expected 0/0", name, done_v[idx], busy_v[idx]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || out_v[i] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_state[%0d]: busy=%b done=%b out=%h expected 0/0/0",
                         i, busy_v[i], done_v[i], out_v[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        issue_and_check(1, 2'b00, 32'h0000_0001, 31, 32'h8000_0000, "sll31");
        issue_and_check(1, 2'b10, 32'h8000_00F0, 4,  32'hF800_000F, "sra4");
        issue_and_check(1, 2'b01, 32'h8000_00F0, 4,  32'h0800_000F, "srl4");
        issue_and_check(1, 2'b11, 32'h1234_5678, 8,  32'h7812_3456, "rotr8");
        issue_and_check(1, 2'b10, 32'h8765_4321, 31, 32'hFFFF_FFFF, "sra31");
    endtask

    task automatic test_shamt_zero();
        for (int o = 0; o < 4; o++) begin
            issue_and_check(1, 2'(o), 32'hA5A5_1234, 0, 32'hA5A5_1234, "shamt0");
        end
    endtask

    // Start pulses during SHIFT and DONE carry different operands and must be dropped.
    task automatic test_busy_ignore();
        exp_t        e;
        int          cycles;
        int          pulses;
        int          first_at;
        logic [31:0] captured;
        exp_q.push_back('{32'h0030_0000, exp_lat(20, 4)});
        @(negedge clk);
        op_v[1]    = 2'b00;
        in_v[1]    = 32'h0000_0003;
        shamt_v[1] = 5'd20;
        start_v[1] = 1'b1;
        pulses   = 0;
        first_at = 0;
        captured = '0;
        for (cycles = 1; cycles <= 20; cycles++) begin
            @(posedge clk);
            #1;
            start_v[1] = (cycles == 3 || cycles == 6);
            if (cycles == 3 || cycles == 6) begin
                in_v[1]    = 32'hDEAD_BEEF;
                shamt_v[1] = 5'd1;
                op_v[1]    = 2'b11;
            end
            if (done_v[1] === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    captured = out_v[1];
                    first_at = cycles;
                end
            end
        end
        e = exp_q.pop_front();
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL busy_ignore pulses: got %0d expected 1", pulses);
        end
        tests_run++;
        if (captured !== e.dat) begin
            tests_failed++;
            $display("FAIL busy_ignore data: got %h expected %h", captured, e.dat);
        end
        tests_run++;
        if (first_at != e.lat) begin
            tests_failed++;
            $display("FAIL busy_ignore latency: got %0d expected %0d", first_at, e.lat);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        op_v[1]    = 2'b00;
        in_v[1]    = 32'hFFFF_FFFF;
        shamt_v[1] = 5'd20;
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0 || out_v[1] !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid state: busy=%b done=%b out=%h expected 0/0/0",
                     busy_v[1], done_v[1], out_v[1]);
        end
        reset  = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done_v[1] === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL reset_mid stray_done: got %0d pulses expected 0", pulses);
        end
        issue_and_check(1, 2'b01, 32'hF0F0_0000, 20, 32'h0000_0F0F, "post_reset");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] data;
        int          sh;
        for (int idx = 0; idx < 3; idx++) begin
            issue_and_check(idx, 2'b11, 32'hC000_0001, 31, ref_shift(2'b11, 32'hC000_0001, 31), "rand_rotr31");
            for (int n = 0; n < 15; n++) begin
                op   = 2'($urandom);
                data = $urandom;
                sh   = int'($urandom_range(0, 31));
                issue_and_check(idx, op, data, sh, ref_shift(op, data, sh), "random");
            end
        end
    endtask

    task automatic test_back_to_back();
        issue_and_check(2, 2'b00, 32'h0000_FFFF, 16, 32'hFFFF_0000, "b2b_a");
        issue_and_check(2, 2'b10, 32'h8000_0000, 3,  32'hF000_0000, "b2b_b");
        issue_and_check(0, 2'b01, 32'h8000_0000, 5,  32'h0400_0000, "b2b_c");
    endtask

    initial begin
        reset   = 1'b1;
        start_v = '0;
        op_v    = '0;
        in_v    = '0;
        shamt_v = '0;
        test_reset();
        test_directed();
        test_shamt_zero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
